// File: rtl/coin_balance_timer_pkg.sv
// Shared vending-machine definitions: coin denominations, FSM encodings and
// the default inactivity timeout.
package coin_balance_timer_pkg;

    localparam int MAX_COINS = 3;

    // Denominations must stay in ascending order; the change picker relies on it.
    localparam int unsigned COIN_VALUE [MAX_COINS] = '{100, 500, 1000};

    localparam int unsigned WAIT_CYCLES_DEFAULT = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RETURN = 2'd2
    } state_t;

    // Channels beyond the table are worth nothing, so a wider NUM_COINS stays safe.
    function automatic int unsigned coin_value(input int k);
        if (k >= 0 && k < MAX_COINS) begin
            return COIN_VALUE[k];
        end
        return 0;
    endfunction

endpackage

// File: rtl/coin_balance_timer_picker.sv
// Greedy change selector: one-hot flag of the largest denomination that still
// fits in the given balance, or zero when nothing fits.
module coin_change_picker
    import coin_balance_timer_pkg::*;
#(
    parameter int NUM_COINS = 3,
    parameter int BAL_W     = 16
) (
    input  logic [BAL_W-1:0]     balance,
    output logic [NUM_COINS-1:0] coin
);

    // Ascending table: a later fitting entry is always the larger one.
    always_comb begin
        coin = '0;
        for (int k = 0; k < NUM_COINS; k++) begin
            if (coin_value(k) != 0 && 64'(balance) >= 64'(coin_value(k))) begin
                coin    = '0;
                coin[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/coin_balance_timer.sv
// Coin-operated balance keeper with purchase deduction, inactivity timer and
// greedy coin return through a ready/valid dispenser handshake.
module coin_balance_timer
    import coin_balance_timer_pkg::*;
#(
    parameter int          NUM_COINS   = 3,
    parameter int          BAL_W       = 16,
    parameter int          TIMER_W     = 32,
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_COINS-1:0] i_input_coin,
    input  logic                 i_deduct_valid,
    input  logic [BAL_W-1:0]     i_deduct_amount,
    input  logic                 i_trigger_return,
    input  logic                 i_return_ready,
    output logic                 o_deduct_ok,
    output logic                 o_return_valid,
    output logic [NUM_COINS-1:0] o_return_coin,
    output logic [BAL_W-1:0]     o_balance,
    output logic [TIMER_W-1:0]   o_wait_time,
    output logic                 o_busy
);

    // Extra headroom so balance plus a full cycle of coins never wraps.
    localparam int EXT_W = BAL_W + 16;
    localparam logic [EXT_W-1:0] BAL_MAX  = {{(EXT_W-BAL_W){1'b0}}, {BAL_W{1'b1}}};
    localparam logic [EXT_W-1:0] MIN_COIN = EXT_W'(coin_value(0));

    state_t                state;
    state_t                state_next;
    logic [BAL_W-1:0]      balance;
    logic [BAL_W-1:0]      balance_next;
    logic [TIMER_W-1:0]    timer;
    logic [TIMER_W-1:0]    timer_next;
    logic                  deduct_ok;
    logic                  locked;
    logic [NUM_COINS-1:0]  locked_coin;
    logic [NUM_COINS-1:0]  pick_coin;
    logic [NUM_COINS-1:0]  cur_coin;
    logic [EXT_W-1:0]      coin_sum;
    logic [EXT_W-1:0]      cur_val;
    logic [EXT_W-1:0]      total;
    logic [EXT_W-1:0]      after;
    logic                  accept;
    logic                  reload;
    logic                  handshake;

    coin_change_picker #(
        .NUM_COINS (NUM_COINS),
        .BAL_W     (BAL_W)
    ) u_picker (
        .balance (balance),
        .coin    (pick_coin)
    );

    // A coin offered but not taken is frozen so later inserts cannot swap it.
    assign cur_coin = locked ? locked_coin : pick_coin;

    always_comb begin
        coin_sum = '0;
        cur_val  = '0;
        for (int k = 0; k < NUM_COINS; k++) begin
            if (i_input_coin[k]) begin
                coin_sum = coin_sum + EXT_W'(coin_value(k));
            end
            if (cur_coin[k]) begin
                cur_val = cur_val + EXT_W'(coin_value(k));
            end
        end
    end

    always_comb begin
        handshake = o_return_valid && i_return_ready;
        total     = EXT_W'(balance) + coin_sum;
        accept    = (state != ST_RETURN) && i_deduct_valid &&
                    (EXT_W'(i_deduct_amount) <= total);
        reload    = (state != ST_RETURN) && ((|i_input_coin) || accept);
        after     = total;
        if (accept) begin
            after = total - EXT_W'(i_deduct_amount);
        end
        if (handshake) begin
            after = total - cur_val;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (after != '0) begin
                    state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (after == '0) begin
                    state_next = ST_IDLE;
                end else if (i_trigger_return || (timer == '0 && !reload)) begin
                    state_next = ST_RETURN;
                end
            end
            ST_RETURN: begin
                if (after < MIN_COIN) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy         = (state == ST_RETURN);
        o_return_valid = (state == ST_RETURN) && (cur_coin != '0);
        o_return_coin  = o_return_valid ? cur_coin : '0;
        o_balance      = balance;
        o_wait_time    = timer;
        o_deduct_ok    = deduct_ok;
    end

    // Leaving RETURN discards any residue too small to dispense.
    always_comb begin
        if (state == ST_RETURN && state_next == ST_IDLE) begin
            balance_next = '0;
        end else if (after > BAL_MAX) begin
            balance_next = BAL_MAX[BAL_W-1:0];
        end else begin
            balance_next = after[BAL_W-1:0];
        end

        if (state_next != ST_ACTIVE) begin
            timer_next = '0;
        end else if (reload) begin
            timer_next = TIMER_W'(WAIT_CYCLES);
        end else if (timer != '0) begin
            timer_next = timer - 1'b1;
        end else begin
            timer_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            balance     <= '0;
            timer       <= '0;
            deduct_ok   <= 1'b0;
            locked      <= 1'b0;
            locked_coin <= '0;
        end else begin
            balance   <= balance_next;
            timer     <= timer_next;
            deduct_ok <= accept;
            if (o_return_valid && !i_return_ready && state_next == ST_RETURN) begin
                locked      <= 1'b1;
                locked_coin <= cur_coin;
            end else begin
                locked      <= 1'b0;
                locked_coin <= '0;
            end
        end
    end

endmodule

// File: tb/tb_coin_balance_timer.sv
// Directed bench for coin_balance_timer: hand-computed expectations checked
// with immediate assertions after each clock step.
module tb_coin_balance_timer;

    logic        clk;
    logic        reset_n;
    logic [2:0]  i_input_coin;
    logic        i_deduct_valid;
    logic [15:0] i_deduct_amount;
    logic        i_trigger_return;
    logic        i_return_ready;
    logic        o_deduct_ok;
    logic        o_return_valid;
    logic [2:0]  o_return_coin;
    logic [15:0] o_balance;
    logic [31:0] o_wait_time;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    coin_balance_timer dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_input_coin     (i_input_coin),
        .i_deduct_valid   (i_deduct_valid),
        .i_deduct_amount  (i_deduct_amount),
        .i_trigger_return (i_trigger_return),
        .i_return_ready   (i_return_ready),
        .o_deduct_ok      (o_deduct_ok),
        .o_return_valid   (o_return_valid),
        .o_return_coin    (o_return_coin),
        .o_balance        (o_balance),
        .o_wait_time      (o_wait_time),
        .o_busy           (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [2:0] coin, input logic dv,
                                  input logic [15:0] amt, input logic trig,
                                  input logic rdy);
        i_input_coin     = coin;
        i_deduct_valid   = dv;
        i_deduct_amount  = amt;
        i_trigger_return = trig;
        i_return_ready   = rdy;
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, "_busy"}, 64'(o_busy), 64'd0);
        check_output({tag, "_bal"}, 64'(o_balance), 64'd0);
        check_output({tag, "_wait"}, 64'(o_wait_time), 64'd0);
        check_output({tag, "_valid"}, 64'(o_return_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        apply_stimulus(3'b000, 1'b0, 16'd0, 1'b0, 1'b1);
        #3;
        check_idle("reset");
        check_output("reset_ok", 64'(o_deduct_ok), 64'd0);
        check_output("reset_coin", 64'(o_return_coin), 64'd0);
        #20;
        reset_n = 1'b1;
        tick();
        check_idle("post_reset");

        // Insert 500 then 100, let the timer expire, dispense 500 then 100.
        apply_stimulus(3'b010, 1'b0, 16'd0, 1'b0, 1'b1);
        tick();
        check_output("a_bal500", 64'(o_balance), 64'd500);
        check_output("a_wait_reload", 64'(o_wait_time), 64'd10);
        apply_stimulus(3'b001, 1'b0, 16'd0, 1'b0, 1'b1);
        tick();
        check_output("a_bal600", 64'(o_balance), 64'd600);
        apply_stimulus(3'b000, 1'b0, 16'd0, 1'b0, 1'b1);
        tick();
        check_output("a_wait9", 64'(o_wait_time), 64'd9);
        for (int i = 0; i < 9; i++) tick();
        check_output("a_wait0", 64'(o_wait_time), 64'd0);
        check_output("a_not_yet_busy", 64'(o_busy), 64'd0);
        tick();
        check_output("a_busy", 64'(o_busy), 64'd1);
        check_output("a_coin500", 64'(o_return_coin), 64'b010);
        check_output("a_valid", 64'(o_return_valid), 64'd1);
        tick();
        check_output("a_bal100", 64'(o_balance), 64'd100);
        check_output("a_coin100", 64'(o_return_coin), 64'b001);
        tick();
        check_idle("a_done");

        // Deduct 700 from 1000, then deduct the remaining 300 to reach zero.
        apply_stimulus(3'b100, 1'b0, 16'd0, 1'b0, 1'b1);
        tick();
        check_output("b_bal1000", 64'(o_balance), 64'd1000);
        apply_stimulus(3'b000, 1'b1, 16'd700, 1'b0, 1'b1);
        tick();
        check_output("b_ok", 64'(o_deduct_ok), 64'd1);
        check_output("b_bal300", 64'(o_balance), 64'd300);
        check_output("b_wait10", 64'(o_wait_time), 64'd10);
        apply_stimulus(3'b000, 1'b0, 16'd0, 1'b0, 1'b1);
        tick();
        check_output("b_ok_pulse", 64'(o_deduct_ok), 64'd0);
        check_output("b_wait9", 64'(o_wait_time), 64'd9);
        apply_stimulus(3'b000, 1'b1, 16'd300, 1'b0, 1'b1);
        tick();
        check_output("b_ok_zero", 64'(o_deduct_ok), 64'd1);
        check_idle("b_idle");

        // Deduct 500 against 100 plus a same-cycle 500 insert; then an oversized deduct.
        apply_stimulus(3'b001, 1'b0, 16'd0, 1'b0, 1'b1);
        tick();
        apply_stimulus(3'b010, 1'b1, 16'd500, 1'b0, 1'b1);
        tick();
        check_output("c_ok", 64'(o_deduct_ok), 64'd1);
        check_output("c_bal100", 64'(o_balance), 64'd100);
        apply_stimulus(3'b000, 1'b1, 16'd200, 1'b0, 1'b1);
        tick();
        check_output("c_reject", 64'(o_deduct_ok), 64'd0);
        check_output("c_bal_keep", 64'(o_balance), 64'd100);
        check_output("c_no_reload", 64'(o_wait_time), 64'd9);

        // Saturation: 100 + 65*1000 = 65100, then +1600 clamps at 65535.
        apply_stimulus(3'b100, 1'b0, 16'd0, 1'b0, 1'b1);
        for (int i = 0; i < 65; i++) tick();
        check_output("s_bal65100", 64'(o_balance), 64'd65100);
        apply_stimulus(3'b111, 1'b0, 16'd0, 1'b0, 1'b1);
        tick();
        check_output("s_sat", 64'(o_balance), 64'd65535);
        apply_stimulus(3'b000, 1'b1, 16'd65535, 1'b0, 1'b1);
        tick();
        check_output("s_ok", 64'(o_deduct_ok), 64'd1);
        check_idle("s_idle");

        // Trigger in IDLE is ignored.
        apply_stimulus(3'b000, 1'b0, 16'd0, 1'b1, 1'b1);
        tick();
        check_idle("t_idle_trig");

        // 1600 with dispenser stalled for three cycles.
        apply_stimulus(3'b111, 1'b0, 16'd0, 1'b0, 1'b0);
        tick();
        check_output("d_bal1600", 64'(o_balance), 64'd1600);
        apply_stimulus(3'b000, 1'b0, 16'd0, 1'b1, 1'b0);
        tick();
        check_output("d_busy", 64'(o_busy), 64'd1);
        check_output("d_wait0", 64'(o_wait_time), 64'd0);
        check_output("d_coin1000_a", 64'(o_return_coin), 64'b100);
        apply_stimulus(3'b000, 1'b0, 16'd0, 1'b0, 1'b0);
        tick();
        check_output("d_coin1000_b", 64'(o_return_coin), 64'b100);
        tick();
        check_output("d_coin1000_c", 64'(o_return_coin), 64'b100);
        check_output("d_bal_hold", 64'(o_balance), 64'd1600);
        apply_stimulus(3'b000, 1'b0, 16'd0, 1'b0, 1'b1);
        tick();
        check_output("d_bal600", 64'(o_balance), 64'd600);
        check_output("d_coin500", 64'(o_return_coin), 64'b010);
        tick();
        check_output("d_bal100", 64'(o_balance), 64'd100);
        check_output("d_coin100", 64'(o_return_coin), 64'b001);
        tick();
        check_idle("d_done");

        // Insert 100 and attempt a deduct while 500 is pending in RETURN.
        apply_stimulus(3'b010, 1'b0, 16'd0, 1'b0, 1'b0);
        tick();
        apply_stimulus(3'b000, 1'b0, 16'd0, 1'b1, 1'b0);
        tick();
        check_output("e_coin500", 64'(o_return_coin), 64'b010);
        apply_stimulus(3'b001, 1'b1, 16'd100, 1'b0, 1'b0);
        tick();
        check_output("e_bal600", 64'(o_balance), 64'd600);
        check_output("e_ok0", 64'(o_deduct_ok), 64'd0);
        check_output("e_coin_hold", 64'(o_return_coin), 64'b010);
        apply_stimulus(3'b000, 1'b0, 16'd0, 1'b0, 1'b1);
        tick();
        check_output("e_bal100", 64'(o_balance), 64'd100);
        check_output("e_coin100", 64'(o_return_coin), 64'b001);
        tick();
        check_idle("e_done");

        // Residue below the smallest coin is cleared on leaving RETURN.
        apply_stimulus(3'b001, 1'b0, 16'd0, 1'b0, 1'b1);
        tick();
        apply_stimulus(3'b000, 1'b1, 16'd50, 1'b0, 1'b1);
        tick();
        check_output("r_bal50", 64'(o_balance), 64'd50);
        apply_stimulus(3'b000, 1'b0, 16'd0, 1'b1, 1'b1);
        tick();
        check_output("r_busy", 64'(o_busy), 64'd1);
        check_output("r_novalid", 64'(o_return_valid), 64'd0);
        apply_stimulus(3'b000, 1'b0, 16'd0, 1'b0, 1'b1);
        tick();
        check_idle("r_cleared");

        // Asynchronous reset in the middle of RETURN.
        apply_stimulus(3'b111, 1'b0, 16'd0, 1'b0, 1'b0);
        tick();
        apply_stimulus(3'b000, 1'b0, 16'd0, 1'b1, 1'b0);
        tick();
        check_output("f_busy", 64'(o_busy), 64'd1);
        apply_stimulus(3'b000, 1'b0, 16'd0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle("f_async");
        check_output("f_coin", 64'(o_return_coin), 64'd0);
        check_output("f_ok", 64'(o_deduct_ok), 64'd0);
        #13;
        reset_n = 1'b1;
        tick();
        check_idle("f_release");
        apply_stimulus(3'b010, 1'b0, 16'd0, 1'b0, 1'b1);
        tick();
        check_output("f_bal500", 64'(o_balance), 64'd500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/coin_balance_timer.md
COIN_BALANCE_TIMER -- requirements
Module: coin_balance_timer

Interface
REQ-001 Parameter NUM_COINS, default 3, number of coin denominations/channels.
REQ-002 Parameter BAL_W, default 16, balance register width.
REQ-003 Parameter TIMER_W, default 32, wait-timer width.
REQ-004 Parameter WAIT_CYCLES, default 10, inactivity timeout reload value in clk cycles.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 i_input_coin  input  NUM_COINS  per-cycle insert strobes; bit k adds COIN_VALUE[k]; multiple bits legal.
REQ-008 i_deduct_valid  input  1  purchase request strobe.
REQ-009 i_deduct_amount  input  BAL_W  purchase price, qualified by i_deduct_valid.
REQ-010 i_trigger_return  input  1  user return request.
REQ-011 i_return_ready  input  1  coin dispenser accepts o_return_coin this cycle.
REQ-012 o_deduct_ok  output  1  registered; purchase of previous cycle accepted.
REQ-013 o_return_valid  output  1  o_return_coin holds one coin to dispense.
REQ-014 o_return_coin  output  NUM_COINS  one-hot denomination being dispensed; zero when !o_return_valid.
REQ-015 o_balance  output  BAL_W  current registered balance.
REQ-016 o_wait_time  output  TIMER_W  remaining cycles before auto-return.
REQ-017 o_busy  output  1  high in RETURN state.

Function
REQ-018 FSM states SHALL be IDLE, ACTIVE, RETURN; IDLE->ACTIVE when next balance > 0.
REQ-019 In IDLE/ACTIVE, next balance SHALL be balance + sum of inserted coin values - accepted deduct, all in one cycle.
REQ-020 Deduct SHALL be accepted iff state != RETURN and i_deduct_amount <= balance + this cycle's coin sum; o_deduct_ok high exactly one cycle later.
REQ-021 Balance SHALL saturate at 2^BAL_W-1 on overflow; excess is discarded.
REQ-022 Any coin insert or accepted deduct in IDLE/ACTIVE SHALL reload the timer to WAIT_CYCLES.
REQ-023 Otherwise in ACTIVE the timer SHALL decrement by 1 per cycle, never below 0; in IDLE it holds 0.
REQ-024 ACTIVE->RETURN when timer is 0 with no reload that cycle, or on i_trigger_return; i_trigger_return in IDLE ignored.
REQ-025 ACTIVE->IDLE when balance reaches 0 after a deduct; timer cleared.
REQ-026 In RETURN, o_return_valid SHALL assert with the largest denomination whose value <= balance (greedy).
REQ-027 o_return_coin SHALL remain stable while o_return_valid && !i_return_ready.
REQ-028 On valid && ready, balance SHALL drop by that coin value; next coin selected on the following cycle.
REQ-029 Coins inserted during RETURN SHALL add to balance and be dispensed in the same sequence; timer held 0.
REQ-030 Deduct and i_trigger_return during RETURN SHALL be ignored (o_deduct_ok 0).
REQ-031 RETURN->IDLE when balance < smallest COIN_VALUE; any residue is cleared to 0.

Reset
REQ-032 reset_n low SHALL immediately force IDLE, balance 0, timer 0, all outputs 0, including mid-RETURN.
REQ-033 First state update after reset release SHALL occur on the first rising clk edge with reset_n high.

Structure
REQ-034 COIN_VALUE array (defaults 100, 500, 1000, ascending), FSM state encodings and WAIT_CYCLES default SHALL live in the shared vending-machine definitions package.
REQ-035 Greedy denomination selection SHALL be a combinational sub-module coin_change_picker (balance in, one-hot coin out).

Verification
REQ-036 Insert 500 then 100, ready held 1, no further input -> o_balance 600, timeout after 10 idle cycles, dispense 500 then 100, return to IDLE.
REQ-037 Balance 1000, deduct 700 -> o_deduct_ok 1 next cycle, o_balance 300, timer reloaded to 10.
REQ-038 Balance 100, deduct 500 with simultaneous 500 insert -> accepted, o_balance 100.
REQ-039 RETURN with balance 1600, i_return_ready low 3 cycles -> o_return_coin holds 1000 unchanged; then 1000, 500, 100.
REQ-040 Insert 100 during RETURN with 500 pending -> 500 then 100 dispensed; deduct in same window gives o_deduct_ok 0.
REQ-041 reset_n low mid-RETURN, asynchronous to clk -> all outputs 0 before next edge; IDLE after release.
